// File: rtl/dpram_be_pipe.sv
// dpram_be_pipe: true dual-port RAM with byte write masks, per-port read-during-write
// mode, optional output register, read-valid strobes and write-write collision flag
module dpram_be_pipe #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE_A = 0,
    parameter int RDW_MODE_B = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                valida,
    input  logic                enb,
    input  logic [DATA_W/8-1:0] web,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dinb,
    output logic [DATA_W-1:0]   doutb,
    output logic                validb,
    output logic                coll
);
    localparam int NB = DATA_W / 8;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] qa, qb;
    logic              va, vb;
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] din,
                                                input logic [NB-1:0] we,
                                                input logic wf);
        merge = old;
        for (int i = 0; i < NB; i++)
            if (wf && we[i]) merge[8*i +: 8] = din[8*i +: 8];
    endfunction
    // port A is written last so it wins bytes both ports write
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (enb && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
                if (ena && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            va   <= 1'b0;
            vb   <= 1'b0;
            qa   <= '0;
            qb   <= '0;
            coll <= 1'b0;
        end else begin
            va   <= ena;
            vb   <= enb;
            coll <= ena && enb && (addra == addrb) && |(wea & web);
            if (ena) qa <= merge(mem[addra], dina, wea, RDW_MODE_A != 0);
            if (enb) qb <= merge(mem[addrb], dinb, web, RDW_MODE_B != 0);
        end
    end
    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATA_W-1:0] ra, rb;
            logic              rva, rvb;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ra  <= '0;
                    rb  <= '0;
                    rva <= 1'b0;
                    rvb <= 1'b0;
                end else begin
                    rva <= va;
                    rvb <= vb;
                    if (va) ra <= qa;
                    if (vb) rb <= qb;
                end
            end
            assign douta  = ra;
            assign doutb  = rb;
            assign valida = rva;
            assign validb = rvb;
        end else begin : g_direct
            assign douta  = qa;
            assign doutb  = qb;
            assign valida = va;
            assign validb = vb;
        end
    endgenerate
endmodule

// File: tb/tb_dpram_be_pipe.sv
// tb_dpram_be_pipe: directed bench; u0 is latency-1 read-first, u1 is latency-2 with
// write-first on port A, both fed the same stimulus
module tb_dpram_be_pipe;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ena = 1'b0, enb = 1'b0;
    logic [1:0]  wea = '0, web = '0;
    logic [7:0]  addra = '0, addrb = '0;
    logic [15:0] dina = '0, dinb = '0;
    logic [15:0] douta0, doutb0, douta1, doutb1;
    logic        valida0, validb0, coll0, valida1, validb1, coll1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    dpram_be_pipe #(.DATA_W(16), .ADDR_W(8), .OUT_REG(0), .RDW_MODE_A(0), .RDW_MODE_B(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta0), .valida(valida0), .enb(enb), .web(web), .addrb(addrb),
        .dinb(dinb), .doutb(doutb0), .validb(validb0), .coll(coll0));
    dpram_be_pipe #(.DATA_W(16), .ADDR_W(8), .OUT_REG(1), .RDW_MODE_A(1), .RDW_MODE_B(0)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta1), .valida(valida1), .enb(enb), .web(web), .addrb(addrb),
        .dinb(dinb), .doutb(doutb1), .validb(validb1), .coll(coll1));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pa(input logic en, input logic [1:0] we, input logic [7:0] ad, input logic [15:0] d);
        ena = en; wea = we; addra = ad; dina = d;
    endtask

    task automatic pb(input logic en, input logic [1:0] we, input logic [7:0] ad, input logic [15:0] d);
        enb = en; web = we; addrb = ad; dinb = d;
    endtask

    task automatic idle();
        pa(1'b0, 2'b00, 8'h00, 16'h0000);
        pb(1'b0, 2'b00, 8'h00, 16'h0000);
    endtask

    initial begin
        tick(); tick();
        chk("rst_douta0", douta0, 16'h0);
        chk("rst_valida0", {15'b0, valida0}, 16'h0);
        chk("rst_douta1", douta1, 16'h0);
        chk("rst_coll", {14'b0, coll0, coll1}, 16'h0);
        rst = 1'b0;
        // basic write / cross read
        pa(1'b1, 2'b11, 8'h01, 16'hA0A1); pb(1'b1, 2'b11, 8'h02, 16'hB0B1); tick();
        chk("wr_valid0", {14'b0, valida0, validb0}, 16'h3);
        chk("wr_coll0", {15'b0, coll0}, 16'h0);
        pa(1'b1, 2'b00, 8'h02, 16'h0); pb(1'b1, 2'b00, 8'h01, 16'h0); tick();
        chk("rd_douta0", douta0, 16'hB0B1);
        chk("rd_doutb0", doutb0, 16'hA0A1);
        chk("wf_douta1", douta1, 16'hA0A1);
        chk("wf_valida1", {15'b0, valida1}, 16'h1);
        idle(); tick();
        chk("idle_valid0", {14'b0, valida0, validb0}, 16'h0);
        chk("hold_douta0", douta0, 16'hB0B1);
        chk("lat2_douta1", douta1, 16'hB0B1);
        chk("lat2_valida1", {15'b0, valida1}, 16'h1);
        tick();
        chk("idle_valida1", {15'b0, valida1}, 16'h0);
        chk("hold_douta1", douta1, 16'hB0B1);
        // byte mask
        pa(1'b1, 2'b11, 8'h05, 16'h1234); tick();
        pa(1'b1, 2'b01, 8'h05, 16'hFFFF); tick();
        chk("mask_rf0", douta0, 16'h1234);
        pa(1'b1, 2'b00, 8'h05, 16'h0); tick();
        chk("mask_rd0", douta0, 16'h12FF);
        chk("mask_wf1", douta1, 16'h12FF);
        idle(); tick();
        chk("mask_rd1", douta1, 16'h12FF);
        // read-during-write
        pa(1'b1, 2'b11, 8'h07, 16'h0A0A); tick();
        pa(1'b1, 2'b11, 8'h07, 16'h5555); tick();
        chk("rdw_rf0", douta0, 16'h0A0A);
        pa(1'b1, 2'b00, 8'h07, 16'h0); tick();
        chk("rdw_rd0", douta0, 16'h5555);
        chk("rdw_wf1", douta1, 16'h5555);
        idle(); tick();
        chk("rdw_rd1", douta1, 16'h5555);
        // write-write collision
        pa(1'b1, 2'b10, 8'h08, 16'h1111); pb(1'b1, 2'b11, 8'h08, 16'h2222); tick();
        chk("coll0", {15'b0, coll0}, 16'h1);
        chk("coll1", {15'b0, coll1}, 16'h1);
        pa(1'b1, 2'b00, 8'h08, 16'h0); pb(1'b0, 2'b00, 8'h00, 16'h0); tick();
        chk("coll_pulse", {14'b0, coll0, coll1}, 16'h0);
        chk("coll_data0", douta0, 16'h1122);
        idle(); tick();
        chk("coll_data1", douta1, 16'h1122);
        // disjoint masks at same address are not a collision
        pa(1'b1, 2'b01, 8'h0A, 16'h00AA); pb(1'b1, 2'b10, 8'h0A, 16'hBB00); tick();
        chk("nocoll", {15'b0, coll0}, 16'h0);
        pa(1'b1, 2'b00, 8'h0A, 16'h0); pb(1'b0, 2'b00, 8'h00, 16'h0); tick();
        chk("nocoll_data", douta0, 16'hBBAA);
        // cross-port read during write returns old data
        pa(1'b1, 2'b00, 8'hFF, 16'h0); pb(1'b1, 2'b11, 8'hFF, 16'h7777); tick();
        pa(1'b1, 2'b00, 8'hFF, 16'h0); pb(1'b1, 2'b11, 8'hFF, 16'h8888); tick();
        chk("xport_old", douta0, 16'h7777);
        chk("xport_valid", {15'b0, coll0}, 16'h0);
        // OUT_REG=1 back-to-back latency
        pa(1'b1, 2'b11, 8'h03, 16'h3333); pb(1'b0, 2'b00, 8'h00, 16'h0); tick();
        idle(); tick(); tick();
        pa(1'b1, 2'b00, 8'h01, 16'h0); tick();
        chk("pipe_n0_v", {15'b0, valida1}, 16'h0);
        pa(1'b1, 2'b00, 8'h02, 16'h0); tick();
        chk("pipe_n1_d", douta1, 16'hA0A1);
        chk("pipe_n1_v", {15'b0, valida1}, 16'h1);
        pa(1'b1, 2'b00, 8'h03, 16'h0); tick();
        chk("pipe_n2_d", douta1, 16'hB0B1);
        chk("pipe_n2_v", {15'b0, valida1}, 16'h1);
        idle(); tick();
        chk("pipe_n3_d", douta1, 16'h3333);
        chk("pipe_n3_v", {15'b0, valida1}, 16'h1);
        tick();
        chk("pipe_n4_v", {15'b0, valida1}, 16'h0);
        // reset mid-operation
        pa(1'b1, 2'b11, 8'h09, 16'h9999); tick();
        idle(); tick(); tick();
        pa(1'b1, 2'b00, 8'h09, 16'h0); tick();
        rst = 1'b1; pa(1'b1, 2'b11, 8'h09, 16'hDEAD); tick();
        chk("rst_mid_v1", {15'b0, valida1}, 16'h0);
        chk("rst_mid_d1", douta1, 16'h0);
        chk("rst_mid_d0", douta0, 16'h0);
        rst = 1'b0; idle(); tick();
        chk("flush_v1", {15'b0, valida1}, 16'h0);
        chk("flush_d1", douta1, 16'h0);
        pa(1'b1, 2'b00, 8'h09, 16'h0); tick();
        chk("rst_nowr0", douta0, 16'h9999);
        idle(); tick();
        chk("rst_nowr1", douta1, 16'h9999);
        chk("rst_nowr_v1", {15'b0, valida1}, 16'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
